// File: rtl/perf_report_tx.sv
// Pipeline performance counters: counts events until the HALT instruction is
// fetched, then streams an 8-word report over a valid/ready handshake.
module perf_report_tx #(
    parameter int          CNT_W     = 32,
    parameter int          WARMUP    = 4,
    parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      inst_fetched,
    input  logic             flush,
    input  logic             stall,
    input  logic             branch,
    input  logic             jump,
    input  logic             mem_read_en,
    input  logic             mem_write_en,
    input  logic [1:0]       fwd_sel_a,
    input  logic [1:0]       fwd_sel_b,
    input  logic             ex_alu_src,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_data,
    output logic [2:0]       rpt_idx,
    output logic             rpt_last,
    output logic             done
);

    typedef enum logic [1:0] {S_COUNT, S_DUMP, S_DONE} state_t;

    localparam int N_CNT = 7;
    localparam int C_CYC = 0, C_FLS = 1, C_STL = 2, C_FWD = 3, C_BR = 4, C_JMP = 5, C_MEM = 6;
    localparam logic [CNT_W+1:0] EXT_WARMUP = (CNT_W+2)'(WARMUP);

    state_t                        r_state;
    state_t                        w_state_next;
    logic [2:0]                    r_idx;
    logic                          w_counting;
    logic                          w_fwd;
    logic [N_CNT-1:0]              w_inc;
    logic [N_CNT-1:0][CNT_W-1:0]   w_cnt;
    logic signed [CNT_W+1:0]       w_exec_s;
    logic [CNT_W-1:0]              w_executed;

    assign w_counting = (r_state == S_COUNT) && (inst_fetched != HALT_WORD);
    assign w_fwd      = ((fwd_sel_a != 2'b00) || (fwd_sel_b != 2'b00)) && !ex_alu_src;

    always_comb begin
        w_inc = '0;
        if (w_counting) begin
            w_inc = {(mem_read_en | mem_write_en), jump, branch, w_fwd, stall, flush, 1'b1};
        end
    end

    // One saturating counter per event; increment is suppressed at all-ones.
    genvar gi;
    generate
        for (gi = 0; gi < N_CNT; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (w_inc[gi] && (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            assign w_cnt[gi] = r_cnt;
        end
    endgenerate

    // Flushes and stalls never exceed cycles, so two extra bits cannot overflow.
    assign w_exec_s   = $signed({2'b00, w_cnt[C_CYC]}) - $signed(EXT_WARMUP)
                      - $signed({2'b00, w_cnt[C_FLS]}) - $signed({2'b00, w_cnt[C_STL]});
    assign w_executed = w_exec_s[CNT_W+1] ? '0 : CNT_W'(w_exec_s);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_COUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
        end else if ((r_state == S_DUMP) && rpt_ready) begin
            r_idx <= r_idx + 3'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_COUNT: if (inst_fetched == HALT_WORD) w_state_next = S_DUMP;
            S_DUMP:  if (rpt_ready && (r_idx == 3'd7)) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_DONE;
            default: w_state_next = S_COUNT;
        endcase
    end

    always_comb begin
        rpt_valid = 1'b0;
        rpt_data  = '0;
        rpt_idx   = '0;
        rpt_last  = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_DUMP: begin
                rpt_valid = 1'b1;
                rpt_idx   = r_idx;
                rpt_last  = (r_idx == 3'd7);
                case (r_idx)
                    3'd0:    rpt_data = w_cnt[C_CYC];
                    3'd1:    rpt_data = w_cnt[C_FLS];
                    3'd2:    rpt_data = w_cnt[C_STL];
                    3'd3:    rpt_data = w_executed;
                    3'd4:    rpt_data = w_cnt[C_FWD];
                    3'd5:    rpt_data = w_cnt[C_BR];
                    3'd6:    rpt_data = w_cnt[C_JMP];
                    default: rpt_data = w_cnt[C_MEM];
                endcase
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_perf_report_tx.sv
// Bench for perf_report_tx: a 32-bit and a 4-bit instance share stimulus; report
// words are checked against a table of directed cases and a count-based model.
module tb_perf_report_tx;

    localparam logic [31:0] HALT = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst_fetched;
    logic        flush, stall, branch, jump, mem_read_en, mem_write_en, ex_alu_src;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic        rpt_ready;

    logic        v32, l32, d32, v4, l4, d4;
    logic [31:0] data32;
    logic [3:0]  data4;
    logic [2:0]  idx32, idx4;

    int n_tests = 0;
    int n_fail  = 0;

    // Event totals since the last reset: cycles, flush, stall, branch, jump, mem, fwd
    longint cnt [7];

    typedef logic [7:0][31:0] words_t;

    typedef struct {
        string  name;
        int     n_cyc, n_fl, n_st, n_br, n_jp, n_mem, n_fwd, n_imm;
        int     mode;
        words_t exp32;
        words_t exp4;
    } vec_t;

    vec_t vecs [4];

    perf_report_tx u_dut (
        .clk(clk), .reset(reset), .inst_fetched(inst_fetched), .flush(flush), .stall(stall),
        .branch(branch), .jump(jump), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .ex_alu_src(ex_alu_src),
        .rpt_valid(v32), .rpt_ready(rpt_ready), .rpt_data(data32), .rpt_idx(idx32),
        .rpt_last(l32), .done(d32)
    );

    perf_report_tx #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .inst_fetched(inst_fetched), .flush(flush), .stall(stall),
        .branch(branch), .jump(jump), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .ex_alu_src(ex_alu_src),
        .rpt_valid(v4), .rpt_ready(rpt_ready), .rpt_data(data4), .rpt_idx(idx4),
        .rpt_last(l4), .done(d4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic words_t pack8(input longint w0, w1, w2, w3, w4, w5, w6, w7);
        words_t r;
        r[0] = 32'(w0); r[1] = 32'(w1); r[2] = 32'(w2); r[3] = 32'(w3);
        r[4] = 32'(w4); r[5] = 32'(w5); r[6] = 32'(w6); r[7] = 32'(w7);
        return r;
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Expected report from raw event totals for a counter width w.
    function automatic words_t model_words(input int w);
        longint ex;
        ex = sat(cnt[0], w) - 4 - sat(cnt[1], w) - sat(cnt[2], w);
        if (ex < 0) ex = 0;
        return pack8(sat(cnt[0], w), sat(cnt[1], w), sat(cnt[2], w), ex,
                     sat(cnt[6], w), sat(cnt[3], w), sat(cnt[4], w), sat(cnt[5], w));
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] v;
        v = $urandom;
        if (v == HALT) v = 32'h0;
        return v;
    endfunction

    task automatic rand_events();
        flush = 1'($urandom); stall = 1'($urandom); branch = 1'($urandom); jump = 1'($urandom);
        mem_read_en = 1'($urandom); mem_write_en = 1'($urandom);
        fwd_sel_a = 2'($urandom); fwd_sel_b = 2'($urandom); ex_alu_src = 1'($urandom);
    endtask

    task automatic check_idle(input string nm, input logic exp_done);
        chk({nm, " valid32"}, 64'(v32), 64'(0));
        chk({nm, " data32"},  64'(data32), 64'(0));
        chk({nm, " idx32"},   64'(idx32), 64'(0));
        chk({nm, " last32"},  64'(l32), 64'(0));
        chk({nm, " done32"},  64'(d32), 64'(exp_done));
        chk({nm, " valid4"},  64'(v4), 64'(0));
        chk({nm, " data4"},   64'(data4), 64'(0));
        chk({nm, " done4"},   64'(d4), 64'(exp_done));
    endtask

    // Reset with HALT and ready asserted: both must be overridden.
    task automatic do_reset();
        reset = 1'b1; inst_fetched = HALT; rpt_ready = 1'b1; rand_events();
        @(negedge clk);
        reset = 1'b0; inst_fetched = rand_inst(); rpt_ready = 1'b0;
        for (int i = 0; i < 7; i++) cnt[i] = 0;
        check_idle("reset", 1'b0);
    endtask

    task automatic count_cycle(input logic fl, st, br, jp, rd, wr, input logic [1:0] fa, fb,
                               input logic imm);
        inst_fetched = rand_inst();
        flush = fl; stall = st; branch = br; jump = jp; mem_read_en = rd; mem_write_en = wr;
        fwd_sel_a = fa; fwd_sel_b = fb; ex_alu_src = imm;
        rpt_ready = 1'($urandom);
        cnt[0]++;
        if (fl) cnt[1]++;
        if (st) cnt[2]++;
        if (br) cnt[3]++;
        if (jp) cnt[4]++;
        if (rd || wr) cnt[5]++;
        if ((fa != 0 || fb != 0) && !imm) cnt[6]++;
        @(negedge clk);
        chk("count valid", 64'(v32), 64'(0));
    endtask

    task automatic halt();
        inst_fetched = HALT; rand_events(); rpt_ready = 1'b1;
        @(negedge clk);
    endtask

    // mode 0: ready always high, 1: pattern 1,0,0 repeating, 2: random
    task automatic dump_check(input string nm, input words_t e32, input words_t e4,
                              input int mode, input int n_words);
        int k;
        int cyc;
        logic rdy;
        k = 0; cyc = 0;
        while (k < n_words && cyc < 64) begin
            chk({nm, " valid"}, 64'(v32), 64'(1));
            chk({nm, " idx"},   64'(idx32), 64'(k));
            chk({nm, " data"},  64'(data32), 64'(e32[k]));
            chk({nm, " last"},  64'(l32), 64'(k == 7));
            chk({nm, " done"},  64'(d32), 64'(0));
            chk({nm, " idx4"},  64'(idx4), 64'(k));
            chk({nm, " data4"}, 64'(data4), 64'(e4[k][3:0]));
            chk({nm, " last4"}, 64'(l4), 64'(k == 7));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom);
            endcase
            rpt_ready = rdy;
            rand_events();
            inst_fetched = ($urandom_range(0, 3) == 0) ? HALT : rand_inst();
            if (rdy) begin
                $display("[TB] %s word %0d = %0d", nm, k, data32);
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        if (k < n_words) begin
            n_tests++; n_fail++;
            $display("FAIL %s timeout: got %0d words, expected %0d", nm, k, n_words);
        end
    endtask

    task automatic finish_check(input string nm);
        check_idle({nm, " done"}, 1'b1);
        for (int i = 0; i < 3; i++) begin
            rpt_ready = 1'($urandom); rand_events(); inst_fetched = rand_inst();
            @(negedge clk);
            check_idle({nm, " hold"}, 1'b1);
        end
    endtask

    initial begin
        vecs[0] = '{"idle10", 10, 0, 0, 0, 0, 0, 0, 0, 0,
                    pack8(10, 0, 0, 6, 0, 0, 0, 0), pack8(10, 0, 0, 6, 0, 0, 0, 0)};
        vecs[1] = '{"mix20", 20, 3, 2, 4, 1, 5, 3, 1, 0,
                    pack8(20, 3, 2, 11, 3, 4, 1, 5), pack8(15, 3, 2, 6, 3, 4, 1, 5)};
        vecs[2] = '{"short2", 2, 0, 0, 0, 0, 0, 0, 0, 1,
                    pack8(2, 0, 0, 0, 0, 0, 0, 0), pack8(2, 0, 0, 0, 0, 0, 0, 0)};
        vecs[3] = '{"stall20", 20, 0, 20, 0, 0, 0, 0, 0, 0,
                    pack8(20, 0, 20, 0, 0, 0, 0, 0), pack8(15, 0, 15, 0, 0, 0, 0, 0)};

        reset = 1'b1; inst_fetched = 32'h0; rpt_ready = 1'b0;
        flush = 0; stall = 0; branch = 0; jump = 0; mem_read_en = 0; mem_write_en = 0;
        fwd_sel_a = 0; fwd_sel_b = 0; ex_alu_src = 0;
        @(negedge clk);

        foreach (vecs[v]) begin
            do_reset();
            for (int i = 0; i < vecs[v].n_cyc; i++) begin
                count_cycle(i < vecs[v].n_fl, i < vecs[v].n_st, i < vecs[v].n_br,
                            i < vecs[v].n_jp, 1'b0, i < vecs[v].n_mem,
                            (i < vecs[v].n_fwd + vecs[v].n_imm) ? 2'b01 : 2'b00, 2'b00,
                            (i >= vecs[v].n_fwd) && (i < vecs[v].n_fwd + vecs[v].n_imm));
            end
            halt();
            dump_check(vecs[v].name, vecs[v].exp32, vecs[v].exp4, vecs[v].mode, 8);
            finish_check(vecs[v].name);
        end

        // Reset in the middle of a dump, then a fresh run
        do_reset();
        for (int i = 0; i < 5; i++) count_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0);
        halt();
        dump_check("middump", model_words(32), model_words(4), 0, 4);
        chk("middump idx before reset", 64'(idx32), 64'(4));
        do_reset();
        for (int i = 0; i < 7; i++) count_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11, 1'b0);
        halt();
        dump_check("rerun", model_words(32), model_words(4), 2, 8);
        finish_check("rerun");

        // Randomized programs checked against the count model
        for (int r = 0; r < 6; r++) begin
            int n;
            do_reset();
            n = $urandom_range(0, 40);
            for (int i = 0; i < n; i++) begin
                count_cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                            1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                            1'($urandom));
            end
            halt();
            dump_check($sformatf("rand%0d", r), model_words(32), model_words(4), 2, 8);
            finish_check($sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
